// File: rtl/seven_seg_scanner_if.sv
// Display-data bundle feeding the 7-segment scanner: per-digit glyph codes,
// decimal points, blank/blink masks and the global brightness level.
`timescale 1ns/1ps
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [5*NUM_DIGITS-1:0] glyphs;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [3:0]              brightness;

  modport master (output glyphs, dp, blank_mask, blink_mask, brightness);
  modport slave  (input  glyphs, dp, blank_mask, blink_mask, brightness);
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment driver. Each digit slot is 16
// brightness sub-phases of SUB_DIV cycles; display data is latched into shadow
// registers at every frame start so a frame never shows mixed data.
`timescale 1ns/1ps
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SUB_DIV      = 3125,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scanner_if.slave    disp,
  output logic [NUM_DIGITS-1:0] ANODE,
  output logic [7:0]            CATHODE,
  output logic                  frame_tick
);

  localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // Timebase
  logic [SUB_W-1:0] sub_cnt;
  logic [3:0]       phase;
  logic [IDX_W-1:0] idx;

  // Blink state
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;

  // Shadow copies of the display data for the frame being shown
  logic [5*NUM_DIGITS-1:0] sh_glyphs;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic [3:0]              sh_bright;
  logic                    sh_visible;

  // Values in force for the current cycle (live inputs during the frame-start cycle)
  logic [5*NUM_DIGITS-1:0] eff_glyphs;
  logic [NUM_DIGITS-1:0]   eff_dp;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic [NUM_DIGITS-1:0]   eff_blink;
  logic [3:0]              eff_bright;
  logic                    eff_visible;

  logic                  frame_start;
  logic                  slot_start;
  logic [4:0]            cur_glyph;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_blink;
  logic [NUM_DIGITS-1:0] anode_lit;
  logic [6:0]            seg;
  logic                  digit_lit;

  assign slot_start  = (phase == 4'd0) && (sub_cnt == '0);
  assign frame_start = slot_start && (idx == '0);

  // The frame-start cycle already displays the new frame, so it reads the
  // inputs directly while the shadows are being loaded on the same edge.
  assign eff_glyphs  = frame_start ? disp.glyphs     : sh_glyphs;
  assign eff_dp      = frame_start ? disp.dp         : sh_dp;
  assign eff_blank   = frame_start ? disp.blank_mask : sh_blank;
  assign eff_blink   = frame_start ? disp.blink_mask : sh_blink;
  assign eff_bright  = frame_start ? disp.brightness : sh_bright;
  assign eff_visible = frame_start ? blink_on        : sh_visible;

  // Sub-phase counter, brightness phase and digit index advance as one chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      phase   <= 4'd0;
      idx     <= '0;
    end else if (sub_cnt == SUB_LAST) begin
      sub_cnt <= '0;
      phase   <= phase + 4'd1;
      if (phase == 4'hF) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end else begin
      sub_cnt <= sub_cnt + 1'b1;
    end
  end

  // Count frames and flip blink visibility every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Latch display data and the frame's blink visibility at each frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_glyphs  <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      sh_blink   <= '0;
      sh_bright  <= 4'd0;
      sh_visible <= 1'b1;
    end else if (frame_start) begin
      sh_glyphs  <= disp.glyphs;
      sh_dp      <= disp.dp;
      sh_blank   <= disp.blank_mask;
      sh_blink   <= disp.blink_mask;
      sh_bright  <= disp.brightness;
      sh_visible <= blink_on;
    end
  end

  // Pick the data of the digit currently being scanned and its anode pattern
  always_comb begin
    cur_glyph = 5'd31;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    cur_blink = 1'b0;
    anode_lit = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx == IDX_W'(d)) begin
        cur_glyph                  = eff_glyphs[5*d +: 5];
        cur_dp                     = eff_dp[d];
        cur_blank                  = eff_blank[d];
        cur_blink                  = eff_blink[d];
        anode_lit[NUM_DIGITS-1-d]  = 1'b0;
      end
    end
    digit_lit = !cur_blank && !(cur_blink && !eff_visible) && (phase <= eff_bright);
  end

  // Glyph code to active-low segment pattern {g,f,e,d,c,b,a}
  always_comb begin
    seg = 7'b1111111;
    case (cur_glyph)
      5'd0:  seg = 7'b1000000;
      5'd1:  seg = 7'b1111001;
      5'd2:  seg = 7'b0100100;
      5'd3:  seg = 7'b0110000;
      5'd4:  seg = 7'b0011001;
      5'd5:  seg = 7'b0010010;
      5'd6:  seg = 7'b0000010;
      5'd7:  seg = 7'b1111000;
      5'd8:  seg = 7'b0000000;
      5'd9:  seg = 7'b0010000;
      5'd10: seg = 7'b0001000;
      5'd11: seg = 7'b0000011;
      5'd12: seg = 7'b1000110;
      5'd13: seg = 7'b0100001;
      5'd14: seg = 7'b0000110;
      5'd15: seg = 7'b0001110;
      5'd16: seg = 7'b0111111;
      5'd17: seg = 7'b0001100;
      5'd18: seg = 7'b1000111;
      5'd19: seg = 7'b0000111;
      5'd20: seg = 7'b0010001;
      5'd21: seg = 7'b0101111;
      5'd22: seg = 7'b0101011;
      5'd23: seg = 7'b0100011;
      5'd24: seg = 7'b0001001;
      5'd25: seg = 7'b1000001;
      5'd26: seg = 7'b1110111;
      default: seg = 7'b1111111;
    endcase
  end

  // Register the pins; the first cycle of every slot keeps anodes off while
  // the new segments settle, which prevents ghosting of the previous digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ANODE      <= '1;
      CATHODE    <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      ANODE      <= (digit_lit && !slot_start) ? anode_lit : '1;
      CATHODE    <= digit_lit ? {~cur_dp, seg} : 8'hFF;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a cycle-count model of the scan predicts the
// pins every cycle, and directed literal checks pin down key moments.
`timescale 1ns/1ps
module tb_seven_seg_scanner;

  localparam int NUM_DIGITS   = 4;
  localparam int SUB_DIV      = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int SLOT         = 16 * SUB_DIV;
  localparam int FRAME        = NUM_DIGITS * SLOT;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NUM_DIGITS-1:0] ANODE;
  logic [7:0]            CATHODE;
  logic                  frame_tick;

  seven_seg_scanner_if #(.NUM_DIGITS(NUM_DIGITS)) disp_if ();

  seven_seg_scanner #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SUB_DIV     (SUB_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .disp      (disp_if),
    .ANODE     (ANODE),
    .CATHODE   (CATHODE),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference segment table, straight from the glyph list
  logic [6:0] seg_table [32] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
    7'b0111111, 7'b0001100, 7'b1000111, 7'b0000111,
    7'b0010001, 7'b0101111, 7'b0101011, 7'b0100011,
    7'b0001001, 7'b1000001, 7'b1110111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  // Model state: cycles since reset release and the frame's captured data
  int                      pos_cnt = 0;
  int                      m_q, m_fr, m_dg, m_pos, m_ph;
  logic [5*NUM_DIGITS-1:0] snap_glyphs;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_blank, snap_blink;
  logic [3:0]              snap_bright;
  bit                      snap_vis;
  bit                      m_lit;
  logic [NUM_DIGITS-1:0]   exp_anode = '1;
  logic [7:0]              exp_cathode = 8'hFF;
  logic                    exp_tick = 1'b0;

  // Predict the pins for the cycle after each edge from the position in the frame
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_cnt     = 0;
      exp_anode   = '1;
      exp_cathode = 8'hFF;
      exp_tick    = 1'b0;
    end else begin
      m_q  = pos_cnt % FRAME;
      m_fr = pos_cnt / FRAME;
      if (m_q == 0) begin
        snap_glyphs = disp_if.glyphs;
        snap_dp     = disp_if.dp;
        snap_blank  = disp_if.blank_mask;
        snap_blink  = disp_if.blink_mask;
        snap_bright = disp_if.brightness;
        snap_vis    = ((m_fr / BLINK_FRAMES) % 2) == 0;
      end
      m_dg  = m_q / SLOT;
      m_pos = m_q % SLOT;
      m_ph  = m_pos / SUB_DIV;
      m_lit = !snap_blank[m_dg] && !(snap_blink[m_dg] && !snap_vis) && (m_ph <= int'(snap_bright));
      exp_anode = '1;
      if (m_lit && m_pos != 0) exp_anode[NUM_DIGITS-1-m_dg] = 1'b0;
      exp_cathode = m_lit ? {~snap_dp[m_dg], seg_table[snap_glyphs[5*m_dg +: 5]]} : 8'hFF;
      exp_tick    = (m_q == 0);
      pos_cnt++;
    end
  end

  // Compare every cycle against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (ANODE !== exp_anode || CATHODE !== exp_cathode || frame_tick !== exp_tick) begin
        errors++;
        $display("[TB] FAIL scan t=%0d: got ANODE=%b CATHODE=%b tick=%b, expected ANODE=%b CATHODE=%b tick=%b",
                 pos_cnt, ANODE, CATHODE, frame_tick, exp_anode, exp_cathode, exp_tick);
      end
    end
  end

  function automatic logic [19:0] pack(input int g3, input int g2, input int g1, input int g0);
    return {5'(g3), 5'(g2), 5'(g1), 5'(g0)};
  endfunction

  task automatic applyStimulus(input logic [19:0] g, input logic [3:0] d,
                               input logic [3:0] bl, input logic [3:0] bk,
                               input logic [3:0] br);
    disp_if.glyphs     = g;
    disp_if.dp         = d;
    disp_if.blank_mask = bl;
    disp_if.blink_mask = bk;
    disp_if.brightness = br;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] an,
                             input logic [7:0] cat, input logic tk);
    checks++;
    if (ANODE !== an || CATHODE !== cat || frame_tick !== tk) begin
      errors++;
      $display("[TB] FAIL %s: got ANODE=%b CATHODE=%b tick=%b, expected ANODE=%b CATHODE=%b tick=%b",
               name, ANODE, CATHODE, frame_tick, an, cat, tk);
    end
  endtask

  task automatic waitCycle(input int target);
    int guard = 0;
    while (pos_cnt != target && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (pos_cnt != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait: reached t=%0d, expected t=%0d", pos_cnt, target);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset", 4'hF, 8'hFF, 1'b0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    // Scan and decode with full brightness
    applyStimulus(pack(19, 10, 18, 17), 4'b0010, 4'b0000, 4'b0000, 4'd15);
    doReset();
    waitCycle(1);   checkOutput("a_tick",   4'hF,    8'b10001100, 1'b1);
    waitCycle(2);   checkOutput("a_d0",     4'b0111, 8'b10001100, 1'b0);
    waitCycle(33);  checkOutput("a_gap1",   4'hF,    8'b01000111, 1'b0);
    waitCycle(34);  checkOutput("a_d1",     4'b1011, 8'b01000111, 1'b0);
    waitCycle(66);  checkOutput("a_d2",     4'b1101, 8'b10001000, 1'b0);
    waitCycle(98);  checkOutput("a_d3",     4'b1110, 8'b10000111, 1'b0);
    waitCycle(128); checkOutput("a_d3_end", 4'b1110, 8'b10000111, 1'b0);
    waitCycle(129); checkOutput("a_tick2",  4'hF,    8'b10001100, 1'b1);

    // Brightness 3 then 0
    waitCycle(140);
    applyStimulus(pack(19, 10, 18, 17), 4'b0010, 4'b0000, 4'b0000, 4'd3);
    waitCycle(264); checkOutput("b3_on",  4'b0111, 8'b10001100, 1'b0);
    waitCycle(265); checkOutput("b3_off", 4'hF,    8'hFF,       1'b0);
    waitCycle(300);
    applyStimulus(pack(19, 10, 18, 17), 4'b0010, 4'b0000, 4'b0000, 4'd0);
    waitCycle(386); checkOutput("b0_on",  4'b0111, 8'b10001100, 1'b0);
    waitCycle(387); checkOutput("b0_off", 4'hF,    8'hFF,       1'b0);
    waitCycle(420);

    // Mid-frame glyph change must wait for the next frame
    applyStimulus(pack(0, 0, 0, 0), 4'b0000, 4'b0000, 4'b0000, 4'd15);
    doReset();
    waitCycle(40);
    applyStimulus(pack(8, 8, 8, 8), 4'b0000, 4'b0000, 4'b0000, 4'd15);
    waitCycle(50);  checkOutput("t_d1_old", 4'b1011, 8'hC0, 1'b0);
    waitCycle(100); checkOutput("t_d3_old", 4'b1110, 8'hC0, 1'b0);
    waitCycle(129); checkOutput("t_tick",   4'hF,    8'h80, 1'b1);
    waitCycle(130); checkOutput("t_d0_new", 4'b0111, 8'h80, 1'b0);
    waitCycle(163); checkOutput("t_d1_new", 4'b1011, 8'h80, 1'b0);

    // Blink on digit 0, blank on digit 3, blank glyph code on digit 2
    applyStimulus(pack(24, 28, 21, 22), 4'b0001, 4'b1000, 4'b0001, 4'd15);
    doReset();
    waitCycle(2);   checkOutput("c_d0_f0",   4'b0111, 8'b00101011, 1'b0);
    waitCycle(34);  checkOutput("c_d1",      4'b1011, 8'b10101111, 1'b0);
    waitCycle(66);  checkOutput("c_d2_code", 4'b1101, 8'hFF,       1'b0);
    waitCycle(98);  checkOutput("c_d3_blank",4'hF,    8'hFF,       1'b0);
    waitCycle(258); checkOutput("c_d0_f2",   4'hF,    8'hFF,       1'b0);
    waitCycle(386); checkOutput("c_d0_f3",   4'hF,    8'hFF,       1'b0);
    waitCycle(514); checkOutput("c_d0_f4",   4'b0111, 8'b00101011, 1'b0);
    waitCycle(642); checkOutput("c_d0_f5",   4'b0111, 8'b00101011, 1'b0);
    waitCycle(770); checkOutput("c_d0_f6",   4'hF,    8'hFF,       1'b0);
    waitCycle(780);

    // Asynchronous reset in the middle of a slot
    applyStimulus(pack(19, 10, 18, 17), 4'b0010, 4'b0000, 4'b0000, 4'd15);
    doReset();
    waitCycle(70);  checkOutput("d_pre", 4'b1101, 8'b10001000, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("d_async", 4'hF, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    waitCycle(1);   checkOutput("d_tick", 4'hF,    8'b10001100, 1'b1);
    waitCycle(2);   checkOutput("d_d0",   4'b0111, 8'b10001100, 1'b0);

    // Sweep all 32 glyph codes with varied dp, blink and brightness
    for (int k = 0; k < 8; k++) begin
      waitCycle(FRAME * k + 64);
      applyStimulus(pack(4*k + 3, 4*k + 2, 4*k + 1, 4*k), 4'($urandom),
                    4'b0000, 4'($urandom_range(0, 15)), 4'(2 * k + 1));
    end
    waitCycle(FRAME * 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised time-multiplexed driver for common-anode 7-segment displays with a NUM_DIGITS-digit scan.
- Full 5-bit glyph decoder covering hex digits plus status letters, with per-digit decimal point, blanking and blink.
- Global PWM brightness control.
- Display data is double-buffered and updated only at frame boundaries, so digits never tear mid-scan.
- Sits between game/instrument status logic and the board's ANODE/CATHODE pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
SUB_DIV, 3125, clk cycles per brightness sub-phase; one digit slot = 16*SUB_DIV cycles
BLINK_FRAMES, 250, frames per blink half-period (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
glyphs  input  5*NUM_DIGITS  glyph code per digit; digit d at [5d+4:5d]; digit 0 leftmost
dp  input  NUM_DIGITS  decimal point on per digit (1 = lit)
blank_mask  input  NUM_DIGITS  1 = digit forced dark
blink_mask  input  NUM_DIGITS  1 = digit dark during blink off-phase
brightness  input  4  duty level; 0 = 1/16 on, 15 = 16/16 on
ANODE  output  NUM_DIGITS  active-low digit enables; digit d drives bit NUM_DIGITS-1-d
CATHODE  output  8  active-low segments; [7]=dp, [6:0]=g,f,e,d,c,b,a
frame_tick  output  1  one-cycle pulse at each frame start

Behaviour:
- Reset (async, rst_n=0):
  - sub_cnt, phase (4b), idx and blink frame counter = 0; blink_on = 1 (visible).
  - Shadow registers for glyphs, dp, masks and brightness = 0.
  - ANODE = all 1s; CATHODE = 8'hFF; frame_tick = 0.
  - Outputs take these values immediately on rst_n assertion. Reset mid-frame discards the partial frame.
- Timebase:
  - sub_cnt counts 0..SUB_DIV-1. On wrap, phase increments (mod 16).
  - When phase wraps 15->0, idx increments. idx wraps NUM_DIGITS-1 -> 0.
- Frame start (idx wrap, and the first slot after reset release):
  - Shadow registers load the current glyphs/dp/blank_mask/blink_mask/brightness.
  - frame_tick pulses for exactly 1 cycle, aligned with the first output cycle of digit 0.
- Blink: the frame counter increments at each frame start. When it reaches BLINK_FRAMES it resets to 0 and toggles blink_on.
- Digit dark when any of these holds: shadow blank_mask[idx]; shadow blink_mask[idx] with blink_on=0; or phase > shadow brightness.
- Outputs are registered, with 1 cycle latency from the timebase state:
  - Digit dark: ANODE = all 1s and CATHODE = 8'hFF.
  - Digit lit: ANODE = one-hot low at bit NUM_DIGITS-1-idx; CATHODE[6:0] = decode(glyph); CATHODE[7] = ~dp.
- At every idx change, ANODE goes all 1s for exactly 1 cycle before the new digit is enabled (anti-ghosting). The new CATHODE is applied in that same dark cycle.
- Decode table (CATHODE[6:0]):
  - Hex digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Letters/symbols: 16 '-'=0111111, 17 P=0001100, 18 L=1000111, 19 t=0000111, 20 Y=0010001, 21 r=0101111, 22 n=0101011, 23 o=0100011, 24 H=0001001, 25 U=1000001, 26 '_'=1110111.
  - Codes 27..31 = blank (1111111).
- Changing the inputs mid-frame has no visible effect until the next frame start.
- An input change on the same cycle as frame start is captured.

Test Plan:
- Sim parameters: NUM_DIGITS=4, SUB_DIV=2, BLINK_FRAMES=2 (slot = 32 cycles, frame = 128 cycles).
- Reset: hold rst_n=0 -> ANODE=4'hF, CATHODE=8'hFF, frame_tick=0. Release -> frame_tick pulses once, then ANODE shows 4'hF for 1 cycle, then 4'b0111.
- Scan/decode: glyphs={d3=19,d2=10,d1=18,d0=17}, brightness=15, masks=0, dp=4'b0010 -> per slot, after the 1-cycle dark gap:
  - d0: ANODE 0111, CATHODE 8'b10001100
  - d1: ANODE 1011, CATHODE 8'b01000111
  - d2: ANODE 1101, CATHODE 8'b10001000
  - d3: ANODE 1110, CATHODE 8'b10000111
  - Each slot then holds for 31 cycles; frame_tick every 128 cycles.
- Brightness: brightness=3 -> each digit is lit for phases 0..3 only (8 cycles minus the gap cycle), dark for the remaining 24 cycles of its slot. brightness=0 -> lit for 2 cycles per slot (1 after the gap).
- Blink/blank: blink_mask=4'b0001, blank_mask=4'b1000 -> digit 3 is never lit. Digit 0 is lit in frames 0-1, dark in frames 2-3, lit again in frames 4-5.
- Tearing: change glyphs from all-0 to all-8 at cycle 40 (during d1) -> d1..d3 still show 8'b11000000 this frame; all digits show 8'b10000000 from the next frame_tick.
- Async reset mid-slot (cycle 70): ANODE=4'hF the same cycle. After release, the scan restarts at digit 0 with a frame_tick.
